stage_if: RTL and testbench
===========================

Name: stage_if

Overview:
- Instruction-fetch stage of the 5-stage RV32I pipeline; sits directly upstream of the IF/ID pipeline register.
- Owns the PC and fetches each 32-bit instruction as four little-endian byte reads through the memory controller's byte-wide fetch port.
- Raises a stall request while a fetch is incomplete.
- Accepts branch/jump redirects from EX.

Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded at reset.
- ADDR_W, 32: width of PC and memory address.
- INST_W, 32: instruction width; fixed at 4 bytes.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low; 0 = reset asserted.
- stall  in  6  global stall vector; bit 0 freezes PC/fetch advance.
- br_flag  in  1  redirect request from EX, single-cycle pulse.
- br_target  in  ADDR_W  redirect target; bits [1:0] ignored and forced to 0.
- mem_req  out  1  byte-read request to the memory controller.
- mem_addr  out  ADDR_W  byte address of the current request.
- mem_ack  in  1  requested byte is on mem_rdata this cycle.
- mem_rdata  in  8  returned byte.
- stall_req  out  1  IF needs the pipeline held; instruction not ready.
- pc_o  out  ADDR_W  PC of the delivered instruction.
- inst_o  out  INST_W  delivered instruction; 0 = bubble.

Behaviour:
- Reset (reset==0, asynchronous):
  - pc=RESET_PC, cnt=0, buf=0, state=FETCH.
  - pc_o=0, inst_o=0, mem_req=0, stall_req=0.
- First cycle after reset release: mem_req=1, mem_addr=RESET_PC.
- State FETCH:
  - mem_req=1, mem_addr=pc+cnt (cnt is 2 bits), stall_req=1, pc_o=0, inst_o=0.
  - On mem_ack with cnt<3: buf[8*cnt+:8]<=mem_rdata; cnt<=cnt+1.
  - On mem_ack with cnt==3:
    - inst_o<={mem_rdata,buf[23:0]}, pc_o<=pc.
    - state<=HOLD, cnt<=0.
  - No mem_ack: hold all state; mem_addr stays stable; request persists.
- State HOLD:
  - mem_req=0, stall_req=0; pc_o/inst_o hold the assembled instruction.
  - If stall[0]==1: remain in HOLD; outputs and pc unchanged.
  - If stall[0]==0: pc<=pc+4 (mod 2^ADDR_W, wrap to 0 at top); state<=FETCH.
  - HOLD lasts at least one cycle, so the downstream register samples the instruction exactly once per unstalled cycle.
- Latency: minimum 5 cycles per instruction (4 ack cycles + 1 HOLD), assuming a back-to-back mem_ack.
- Redirect (br_flag==1) has highest priority over any mem_ack and any stall in the same cycle:
  - pc<={br_target[ADDR_W-1:2],2'b00}; cnt<=0; buf<=0; state<=FETCH.
  - pc_o<=0, inst_o<=0 (flushed instruction becomes bubble).
  - mem_req forced 0 in the br_flag cycle; a byte acked in that cycle is discarded.
  - Fetch from the target begins the following cycle.
- br_flag in consecutive cycles: the last one wins.
- Reset mid-fetch: partial buf discarded; restart at RESET_PC.
- Memory controller contract: mem_ack asserted only while mem_req==1, for the address presented in the same cycle. An ack while mem_req==0 is ignored.
- stall[5:1] are not used here; they are consumed by downstream registers.

Decomposition:
- Shared define package: ADDR_W/INST_W bus macros (`MemAddrBus`, `InstBus`), stall-vector width 6, bubble constant NOP=32'h0, state encoding FETCH/HOLD.
- One sub-module is natural: if_byte_assembler (cnt + buf + little-endian assembly, clear on flush).
- The FSM and PC remain in stage_if.

Test Plan:
- Reset low then high; memory returns bytes 0x13,0x05,0x10,0x00 at 0..3 with immediate ack:
  - mem_addr sequences 0,1,2,3.
  - Cycle 5: inst_o=32'h0010_0513, pc_o=0, stall_req=0.
- Stall hold: in HOLD drive stall[0]=1 for 3 cycles:
  - pc_o/inst_o unchanged, mem_req=0.
  - After release, next fetch mem_addr=4.
- Slow memory: mem_ack only every 3rd cycle:
  - mem_addr holds each byte address until acked; stall_req=1 throughout.
  - Instruction assembled correctly after 12 cycles.
- Redirect mid-fetch: after 2 bytes of the fetch at 0x8, pulse br_flag with br_target=0x103 and mem_ack=1 in the same cycle:
  - Byte discarded, inst_o=0.
  - Next mem_addr=0x100.
- Redirect during HOLD with stall[0]=1: br_flag, target 0x40:
  - inst_o=0 next cycle, fetch resumes at 0x40 despite the stall.
- Wrap-around: RESET_PC=32'hFFFF_FFFC:
  - After the first instruction and stall[0]=0, next mem_addr=0.
- Async reset asserted mid-fetch (between clock edges):
  - Outputs go to 0 immediately.
  - Refetch starts at RESET_PC.

Source files
------------

// File: rtl/stage_if_pkg.sv
// Shared definitions for the instruction-fetch stage: bus widths, stall vector,
// bubble encoding and the fetch FSM state type.
package stage_if_pkg;

  localparam int unsigned MEM_ADDR_W = 32;
  localparam int unsigned INST_BUS_W = 32;
  localparam int unsigned STALL_W    = 6;

  typedef logic [MEM_ADDR_W-1:0] mem_addr_bus_t;
  typedef logic [INST_BUS_W-1:0] inst_bus_t;

  localparam inst_bus_t NOP = 32'h0000_0000;

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } if_state_e;

endpackage

// File: rtl/stage_if_byte_assembler.sv
// Collects four little-endian bytes into one instruction word; a flush clears
// any partially assembled word.
module if_byte_assembler #(
  parameter int unsigned INST_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              ack_i,
  input  logic [7:0]        byte_i,
  output logic [1:0]        cnt_o,
  output logic              done_o,
  output logic [INST_W-1:0] word_o
);

  logic [1:0]        cnt_q, cnt_d;
  logic [INST_W-9:0] buf_q, buf_d;

  // NOTE: every variable gets its default first, so no path leaves it unassigned (no latch).
  always_comb begin
    cnt_d = cnt_q;
    buf_d = buf_q;
    if (clear_i) begin
      cnt_d = '0;
      buf_d = '0;
    end else if (ack_i) begin
      if (cnt_q == 2'd3) begin
        cnt_d = '0;
      end else begin
        buf_d[8*cnt_q +: 8] = byte_i;
        cnt_d               = cnt_q + 2'd1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments and reset asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      buf_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      buf_q <= buf_d;
    end
  end

  assign cnt_o  = cnt_q;
  // The fourth byte is forwarded straight from the bus, never stored.
  assign done_o = ack_i & ~clear_i & (cnt_q == 2'd3);
  assign word_o = {byte_i, buf_q};

endmodule

// File: rtl/stage_if.sv
// RV32I instruction-fetch stage: owns the PC, fetches each instruction as four
// byte reads, holds it for one unstalled cycle and accepts redirects from EX.
module stage_if
  import stage_if_pkg::*;
#(
  parameter int unsigned          ADDR_W   = MEM_ADDR_W,
  parameter int unsigned          INST_W   = INST_BUS_W,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [STALL_W-1:0] stall,
  input  logic               br_flag,
  input  logic [ADDR_W-1:0]  br_target,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [7:0]         mem_rdata,
  output logic               stall_req,
  output logic [ADDR_W-1:0]  pc_o,
  output logic [INST_W-1:0]  inst_o
);

  if_state_e         state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pc_out_q, pc_out_d;
  logic [INST_W-1:0] inst_q, inst_d;

  logic [1:0]        cnt;
  logic              word_done;
  logic [INST_W-1:0] word;
  logic              fetch_ack;

  // Only stall[0] and the word-aligned part of the target matter to this stage.
  logic unused_inputs;
  assign unused_inputs = ^{stall[STALL_W-1:1], br_target[1:0]};

  assign mem_req   = reset & (state_q == FETCH) & ~br_flag;
  assign stall_req = reset & (state_q == FETCH);
  assign mem_addr  = pc_q + ADDR_W'(cnt);
  assign fetch_ack = mem_req & mem_ack;

  if_byte_assembler #(
    .INST_W (INST_W)
  ) u_asm (
    .clk     (clock),
    .rst_n   (reset),
    .clear_i (br_flag),
    .ack_i   (fetch_ack),
    .byte_i  (mem_rdata),
    .cnt_o   (cnt),
    .done_o  (word_done),
    .word_o  (word)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pc_out_d = pc_out_q;
    inst_d   = inst_q;
    if (br_flag) begin
      // Redirect outranks acks and stalls; the flushed slot becomes a bubble.
      pc_d     = {br_target[ADDR_W-1:2], 2'b00};
      state_d  = FETCH;
      pc_out_d = '0;
      inst_d   = INST_W'(NOP);
    end else begin
      unique case (state_q)
        FETCH: begin
          if (word_done) begin
            inst_d   = word;
            pc_out_d = pc_q;
            state_d  = HOLD;
          end
        end
        HOLD: begin
          if (!stall[0]) begin
            pc_d     = pc_q + ADDR_W'(4);
            state_d  = FETCH;
            pc_out_d = '0;
            inst_d   = INST_W'(NOP);
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= FETCH;
      pc_q     <= RESET_PC;
      pc_out_q <= '0;
      inst_q   <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pc_out_q <= pc_out_d;
      inst_q   <= inst_d;
    end
  end

  assign pc_o   = pc_out_q;
  assign inst_o = inst_q;

endmodule

// File: tb/tb_stage_if.sv
// Randomized bench for stage_if: a memory responder, an instruction-level
// reference model feeding a scoreboard queue, and an output monitor.
module tb_stage_if;
  import stage_if_pkg::*;

  localparam logic [31:0] RST_PC = 32'hFFFF_FFFC;
  localparam int          CYCLES = 3000;

  logic               clock = 1'b0;
  logic               reset;
  logic [STALL_W-1:0] stall;
  logic               br_flag;
  logic [31:0]        br_target;
  logic               mem_req;
  logic [31:0]        mem_addr;
  logic               mem_ack;
  logic [7:0]         mem_rdata;
  logic               stall_req;
  logic [31:0]        pc_o;
  logic [31:0]        inst_o;

  stage_if #(
    .ADDR_W   (32),
    .INST_W   (32),
    .RESET_PC (RST_PC)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .stall     (stall),
    .br_flag   (br_flag),
    .br_target (br_target),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .stall_req (stall_req),
    .pc_o      (pc_o),
    .inst_o    (inst_o)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        cur;
  int          vectors     = 0;
  int          miscompares = 0;

  logic [31:0] m_pc;
  int          m_cnt;
  bit          m_fetching;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h, expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Byte-addressed memory image; addresses 0..3 hold addi a0,x0,1.
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'd0:   return 8'h13;
      32'd1:   return 8'h05;
      32'd2:   return 8'h10;
      32'd3:   return 8'h00;
      default: return (a[7:0] * 8'd13) ^ a[15:8] ^ a[31:24] ^ 8'h5A;
    endcase
  endfunction

  function automatic exp_t expect_at(input logic [31:0] pc);
    exp_t e;
    e.pc   = pc;
    e.inst = {mem_byte(pc + 3), mem_byte(pc + 2), mem_byte(pc + 1), mem_byte(pc)};
    return e;
  endfunction

  function automatic logic [31:0] pick_target();
    case ($urandom % 4)
      0:       return $urandom;
      1:       return 32'hFFFF_FFF0 | 32'($urandom % 16);
      default: return 32'($urandom_range(0, 511));
    endcase
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_pc       = RST_PC;
    m_cnt      = 0;
    m_fetching = 1'b1;
    exp_q.push_back(expect_at(RST_PC));
  endtask

  // Stimulus, memory responder and reference model.
  initial begin
    reset     = 1'b0;
    stall     = '0;
    br_flag   = 1'b0;
    br_target = '0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    #2;
    check("reset_mem_req", {31'b0, mem_req}, 32'd0);
    check("reset_stall_req", {31'b0, stall_req}, 32'd0);
    check("reset_pc_o", pc_o, 32'd0);
    check("reset_inst_o", inst_o, 32'd0);
    @(negedge clock);

    for (int cyc = 0; cyc < CYCLES; cyc++) begin
      bit do_rst;
      if (!reset) begin
        reset = 1'b1;
        model_reset();
      end
      do_rst  = (cyc % 700 == 350);
      br_flag = (cyc >= 30) && ($urandom % 10 == 0);
      if (br_flag) br_target = pick_target();
      stall   = STALL_W'($urandom);
      #1;
      check("mem_req", {31'b0, mem_req}, {31'b0, (!br_flag && m_fetching)});
      if (mem_req && m_fetching && !br_flag) check("mem_addr", mem_addr, m_pc + 32'(m_cnt));
      mem_ack   = ($urandom % 3 != 0);
      mem_rdata = mem_byte(mem_addr);

      if (do_rst) begin
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_mem_req", {31'b0, mem_req}, 32'd0);
        check("async_rst_stall_req", {31'b0, stall_req}, 32'd0);
        check("async_rst_pc_o", pc_o, 32'd0);
        check("async_rst_inst_o", inst_o, 32'd0);
        mem_ack = 1'b0;
        br_flag = 1'b0;
      end else if (br_flag) begin
        if (m_fetching && exp_q.size() > 0) void'(exp_q.pop_back());
        m_pc       = {br_target[31:2], 2'b00};
        m_cnt      = 0;
        m_fetching = 1'b1;
        exp_q.push_back(expect_at(m_pc));
      end else if (m_fetching) begin
        if (mem_ack) begin
          m_cnt++;
          if (m_cnt == 4) begin
            m_cnt      = 0;
            m_fetching = 1'b0;
          end
        end
      end else if (!stall[0]) begin
        m_pc       = m_pc + 32'd4;
        m_fetching = 1'b1;
        exp_q.push_back(expect_at(m_pc));
      end
      @(negedge clock);
    end

    mem_ack = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Monitor: each entry into HOLD delivers the oldest expected instruction.
  initial begin
    bit prev_hold = 1'b0;
    int idle      = 0;
    forever begin
      @(negedge clock);
      #2;
      if (reset) begin
        if (!stall_req) begin
          if (!prev_hold) begin
            if (exp_q.size() == 0) begin
              vectors++;
              miscompares++;
              $display("FAIL unexpected_delivery: got pc %08h inst %08h, expected none at %0t",
                       pc_o, inst_o, $time);
              cur = {pc_o, inst_o};
            end else begin
              cur = exp_q.pop_front();
              check("pc_o", pc_o, cur.pc);
              check("inst_o", inst_o, cur.inst);
            end
          end else begin
            check("pc_o_hold", pc_o, cur.pc);
            check("inst_o_hold", inst_o, cur.inst);
          end
          prev_hold = 1'b1;
          idle      = 0;
        end else begin
          check("pc_o_bubble", pc_o, 32'd0);
          check("inst_o_bubble", inst_o, 32'd0);
          prev_hold = 1'b0;
          idle++;
          if (idle > 80) begin
            vectors++;
            miscompares++;
            $display("FAIL fetch_timeout: got %0d cycles without delivery, expected at most 80", idle);
            idle = 0;
          end
        end
      end else begin
        prev_hold = 1'b0;
        idle      = 0;
      end
    end
  end

endmodule
